// File: rtl/vec_pkg.sv
// Shared types and constants for the vector issue controller.
// Opcode constants describe the lane-side encoding; the controller itself
// only forwards the opcode.
package vec_pkg;

    typedef enum logic [1:0] {
        s_IDLE  = 2'd0,
        s_ISSUE = 2'd1,
        s_WAIT  = 2'd2,
        s_RESP  = 2'd3
    } state_e;

    localparam logic [3:0] OP_READ       = 4'b1000;
    localparam int         OP_EXT_WR_BIT = 3;
    localparam int         OP_SCALAR_BIT = 2;
    localparam logic [1:0] OP_FMA        = 2'b11;

    // Address width for a register file of els entries, never below one bit.
    function automatic int v_addr_width(input int els);
        return (els > 1) ? $clog2(els) : 1;
    endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear, used as the issue watchdog.
// Only compiled when VEC_ISSUE_TIMEOUT_EN is defined.
`ifdef VEC_ISSUE_TIMEOUT_EN
module bsg_counter_clear_up #(
    parameter int max_val_p    = 63,
    parameter int init_val_p   = 0,
    localparam int ptr_width_lp = (max_val_p > 0) ? $clog2(max_val_p + 1) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    up_i,
    output logic [ptr_width_lp-1:0] count_o
);

    logic [ptr_width_lp-1:0] count_r;

    // Count register: clear has priority over increment.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r <= ptr_width_lp'(init_val_p);
        end else if (clear_i) begin
            count_r <= '0;
        end else if (up_i) begin
            count_r <= count_r + ptr_width_lp'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count_o = count_r;

endmodule
`endif

// File: rtl/vec_issue_ctrl.sv
// Single-instruction issue controller for the vector lane array.
// Accepts one instruction, pulses start to all lanes, holds operands until
// the next acceptance, collects per-lane done pulses and returns a response.
// Optional watchdog: define VEC_ISSUE_TIMEOUT_EN to bound the wait for done.
module vec_issue_ctrl
    import vec_pkg::*;
#(
    parameter int els_p      = 8,
    parameter int lanes_p    = 4,
    parameter int vdw_p      = 8,
    parameter int op_width_p = 4,
    parameter int timeout_p  = 64,
    localparam int v_addr_width_lp = v_addr_width(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    output logic                       ready_o,
    input  logic [op_width_p-1:0]      op_i,
    input  logic [v_addr_width_lp-1:0] vd_i,
    input  logic [v_addr_width_lp-1:0] vs0_i,
    input  logic [v_addr_width_lp-1:0] vs1_i,
    input  logic [v_addr_width_lp-1:0] vs2_i,
    input  logic [vdw_p-1:0]           scalar_i,
    input  logic [lanes_p*vdw_p-1:0]   w_data_i,
    output logic [op_width_p-1:0]      lane_op_o,
    output logic                       lane_start_o,
    output logic [vdw_p-1:0]           lane_scalar_o,
    output logic [lanes_p*vdw_p-1:0]   lane_w_data_o,
    output logic [v_addr_width_lp-1:0] vd_o,
    output logic [v_addr_width_lp-1:0] vs0_o,
    output logic [v_addr_width_lp-1:0] vs1_o,
    output logic [v_addr_width_lp-1:0] vs2_o,
    input  logic [lanes_p-1:0]         lane_done_i,
    output logic                       v_o,
    input  logic                       yumi_i,
    output logic                       err_o
);

    state_e                     state_r, state_n_s;
    logic [lanes_p-1:0]         done_r;
    logic [op_width_p-1:0]      op_r;
    logic [v_addr_width_lp-1:0] vd_r, vs0_r, vs1_r, vs2_r;
    logic [vdw_p-1:0]           scalar_r;
    logic [lanes_p*vdw_p-1:0]   w_data_r;
    logic                       ready_s, start_s, resp_v_s;
    logic                       accept_s, all_done_s, timeout_s;

    assign accept_s   = v_i & ready_s;
    // A final done pulse arriving in the same cycle completes the set.
    assign all_done_s = &(done_r | lane_done_i);

`ifdef VEC_ISSUE_TIMEOUT_EN
    localparam int wd_w_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;
    logic [wd_w_lp-1:0] wd_cnt_s;
    logic               err_r;

    bsg_counter_clear_up #(
        .max_val_p  (timeout_p - 1),
        .init_val_p (0)
    ) wdog (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (state_r == s_ISSUE),
        .up_i    (state_r == s_WAIT),
        .count_o (wd_cnt_s)
    );

    assign timeout_s = (wd_cnt_s == wd_w_lp'(timeout_p - 1));

    // Error flag: set when the watchdog forces a response, cleared when it is taken.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_r <= 1'b0;
        end else if ((state_r == s_WAIT) && !all_done_s && timeout_s) begin
            err_r <= 1'b1;
        end else if ((state_r == s_RESP) && yumi_i) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end

    assign err_o = err_r;
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = 32'(timeout_p);
    assign timeout_s        = 1'b0;
    assign err_o            = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= s_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            s_IDLE: begin
                if (accept_s) state_n_s = s_ISSUE;
                else          state_n_s = s_IDLE;
            end
            s_ISSUE: state_n_s = s_WAIT;
            s_WAIT: begin
                if (all_done_s || timeout_s) state_n_s = s_RESP;
                else                         state_n_s = s_WAIT;
            end
            s_RESP: begin
                if (yumi_i) state_n_s = s_IDLE;
                else        state_n_s = s_RESP;
            end
            default: state_n_s = s_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        ready_s  = 1'b0;
        start_s  = 1'b0;
        resp_v_s = 1'b0;
        case (state_r)
            s_IDLE:  ready_s  = 1'b1;
            s_ISSUE: start_s  = 1'b1;
            s_WAIT:  resp_v_s = 1'b0;
            s_RESP:  resp_v_s = 1'b1;
            default: ready_s  = 1'b0;
        endcase
    end

    // Sticky done collection: cleared at issue, accumulated only while waiting.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            done_r <= '0;
        end else if (state_r == s_ISSUE) begin
            done_r <= '0;
        end else if (state_r == s_WAIT) begin
            done_r <= done_r | lane_done_i;
        end else begin
            done_r <= done_r;
        end
    end

    // Instruction holding registers: loaded on acceptance, stable until the next one.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            op_r     <= '0;
            vd_r     <= '0;
            vs0_r    <= '0;
            vs1_r    <= '0;
            vs2_r    <= '0;
            scalar_r <= '0;
            w_data_r <= '0;
        end else if (accept_s) begin
            op_r     <= op_i;
            vd_r     <= vd_i;
            vs0_r    <= vs0_i;
            vs1_r    <= vs1_i;
            vs2_r    <= vs2_i;
            scalar_r <= scalar_i;
            w_data_r <= w_data_i;
        end else begin
            op_r     <= op_r;
            vd_r     <= vd_r;
            vs0_r    <= vs0_r;
            vs1_r    <= vs1_r;
            vs2_r    <= vs2_r;
            scalar_r <= scalar_r;
            w_data_r <= w_data_r;
        end
    end

    assign ready_o       = ready_s;
    assign lane_start_o  = start_s;
    assign v_o           = resp_v_s;
    assign lane_op_o     = op_r;
    assign vd_o          = vd_r;
    assign vs0_o         = vs0_r;
    assign vs1_o         = vs1_r;
    assign vs2_o         = vs2_r;
    assign lane_scalar_o = scalar_r;
    assign lane_w_data_o = w_data_r;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Randomized self-checking bench for vec_issue_ctrl.
// The reference model is transaction level: each instruction has a set of
// per-lane latencies; the response is expected one cycle after the latest
// lane finishes, and held outputs equal the last accepted instruction.
module tb_vec_issue_ctrl;

    localparam int LANES = 4;
    localparam int VDW   = 8;
    localparam int OPW   = 4;
    localparam int AW    = 3;
    localparam int TO    = 8;

    logic                 clk = 1'b0;
    logic                 reset_i;
    logic                 v_i;
    logic                 ready_o;
    logic [OPW-1:0]       op_i;
    logic [AW-1:0]        vd_i, vs0_i, vs1_i, vs2_i;
    logic [VDW-1:0]       scalar_i;
    logic [LANES*VDW-1:0] w_data_i;
    logic [OPW-1:0]       lane_op_o;
    logic                 lane_start_o;
    logic [VDW-1:0]       lane_scalar_o;
    logic [LANES*VDW-1:0] lane_w_data_o;
    logic [AW-1:0]        vd_o, vs0_o, vs1_o, vs2_o;
    logic [LANES-1:0]     lane_done_i;
    logic                 v_o;
    logic                 yumi_i;
    logic                 err_o;

    always #5 clk = ~clk;

    vec_issue_ctrl #(
        .els_p(8), .lanes_p(LANES), .vdw_p(VDW), .op_width_p(OPW), .timeout_p(TO)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
        .op_i(op_i), .vd_i(vd_i), .vs0_i(vs0_i), .vs1_i(vs1_i), .vs2_i(vs2_i),
        .scalar_i(scalar_i), .w_data_i(w_data_i),
        .lane_op_o(lane_op_o), .lane_start_o(lane_start_o),
        .lane_scalar_o(lane_scalar_o), .lane_w_data_o(lane_w_data_o),
        .vd_o(vd_o), .vs0_o(vs0_o), .vs1_o(vs1_o), .vs2_o(vs2_o),
        .lane_done_i(lane_done_i), .v_o(v_o), .yumi_i(yumi_i), .err_o(err_o)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Model state: the instruction the lanes should currently see.
    logic [55:0] exp_held;
    // Fields of the next instruction to issue.
    logic [OPW-1:0]       nf_op;
    logic [AW-1:0]        nf_vd, nf_vs0, nf_vs1, nf_vs2;
    logic [VDW-1:0]       nf_scalar;
    logic [LANES*VDW-1:0] nf_wdata;
    // Per-lane latency after the start cycle; 0 means the lane never finishes.
    int lat [LANES];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [55:0] held_now();
        return {lane_op_o, vd_o, vs0_o, vs1_o, vs2_o, lane_scalar_o, lane_w_data_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        nf_op     = OPW'($urandom_range(0, 15));
        nf_vd     = AW'($urandom_range(0, 7));
        nf_vs0    = AW'($urandom_range(0, 7));
        nf_vs1    = AW'($urandom_range(0, 7));
        nf_vs2    = AW'($urandom_range(0, 7));
        nf_scalar = VDW'($urandom_range(0, 255));
        nf_wdata  = $urandom();
    endtask

    // Present nf_* in an idle cycle; leaves the bench in the start cycle.
    task automatic accept_fields(input bit noise);
        check_val("ready_before_accept", ready_o, 1'b1);
        v_i = 1'b1; op_i = nf_op; vd_i = nf_vd; vs0_i = nf_vs0; vs1_i = nf_vs1;
        vs2_i = nf_vs2; scalar_i = nf_scalar; w_data_i = nf_wdata;
        lane_done_i = noise ? LANES'($urandom_range(0, 15)) : '0;
        step();
        exp_held = {nf_op, nf_vd, nf_vs0, nf_vs1, nf_vs2, nf_scalar, nf_wdata};
        check_val("start_pulse", lane_start_o, 1'b1);
        check_val("ready_in_issue", ready_o, 1'b0);
        check_val("held_at_issue", held_now(), exp_held);
        // A pending request with different fields must be ignored while busy.
        v_i  = noise;
        op_i = ~nf_op;
        vd_i = ~nf_vd;
        scalar_i = ~nf_scalar;
        // Done pulses in the start cycle are outside the collection window.
        lane_done_i = noise ? LANES'($urandom_range(0, 15)) : '0;
    endtask

    function automatic logic [LANES-1:0] done_mask(input int k);
        logic [LANES-1:0] m = '0;
        for (int l = 0; l < LANES; l++) if (lat[l] == k) m[l] = 1'b1;
        return m;
    endfunction

    task automatic run_txn(input int yd, input bit noise);
        int maxlat = 0;
        logic [LANES-1:0] finished = '0;
        for (int l = 0; l < LANES; l++) if (lat[l] > maxlat) maxlat = lat[l];
        accept_fields(noise);
        for (int k = 1; k <= maxlat; k++) begin
            step();
            check_val("start_once", lane_start_o, 1'b0);
            check_val("no_v_while_wait", v_o, 1'b0);
            check_val("ready_while_wait", ready_o, 1'b0);
            check_val("held_in_wait", held_now(), exp_held);
            lane_done_i = done_mask(k) | (noise ? (LANES'($urandom_range(0, 15)) & finished) : '0);
            finished = finished | done_mask(k);
        end
        step();
        lane_done_i = noise ? LANES'($urandom_range(0, 15)) : '0;
        check_val("v_after_last_done", v_o, 1'b1);
        check_val("err_clean", err_o, 1'b0);
        check_val("held_in_resp", held_now(), exp_held);
        yumi_i = (yd == 0);
        for (int d = 1; d <= yd; d++) begin
            step();
            check_val("v_held_until_yumi", v_o, 1'b1);
            check_val("ready_in_resp", ready_o, 1'b0);
            yumi_i = (d == yd);
        end
        step();
        yumi_i = 1'b0; v_i = 1'b0; lane_done_i = '0;
        check_val("v_drop_after_yumi", v_o, 1'b0);
        check_val("ready_after_yumi", ready_o, 1'b1);
        check_val("held_after_resp", held_now(), exp_held);
    endtask

    initial begin
        reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; lane_done_i = '0;
        op_i = '0; vd_i = '0; vs0_i = '0; vs1_i = '0; vs2_i = '0;
        scalar_i = '0; w_data_i = '0; exp_held = '0;
        step(); step();
        reset_i = 1'b0;
        step();
        check_val("rst_ready", ready_o, 1'b1);
        check_val("rst_v", v_o, 1'b0);
        check_val("rst_start", lane_start_o, 1'b0);
        check_val("rst_err", err_o, 1'b0);
        check_val("rst_held", held_now(), 56'd0);

        // Directed: all lanes done together six cycles after start.
        nf_op = 4'b0000; nf_vd = 3'd3; nf_vs0 = 3'd1; nf_vs1 = 3'd2; nf_vs2 = 3'd0;
        nf_scalar = 8'h5a; nf_wdata = 32'hdeadbeef;
        for (int l = 0; l < LANES; l++) lat[l] = 6;
        run_txn(0, 1'b0);

        // Directed: staggered completion, held request, delayed consume.
        rand_fields();
        lat[0] = 2; lat[1] = 5; lat[2] = 5; lat[3] = 5;
        run_txn(3, 1'b1);

        // Stray done pulses and a lone yumi while idle produce nothing.
        for (int i = 0; i < 4; i++) begin
            lane_done_i = LANES'($urandom_range(1, 15));
            yumi_i = 1'b1;
            step();
            check_val("idle_stray_no_v", v_o, 1'b0);
            check_val("idle_stray_ready", ready_o, 1'b1);
        end
        lane_done_i = '0; yumi_i = 1'b0;

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            rand_fields();
            for (int l = 0; l < LANES; l++) lat[l] = $urandom_range(1, 7);
            run_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end

        // Reset while waiting: back to idle, no response, held cleared.
        rand_fields();
        lat[0] = 9; lat[1] = 9; lat[2] = 9; lat[3] = 9;
        accept_fields(1'b0);
        step(); step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        exp_held = '0;
        check_val("midrst_ready", ready_o, 1'b1);
        check_val("midrst_v", v_o, 1'b0);
        check_val("midrst_held", held_now(), exp_held);
        for (int i = 0; i < 6; i++) begin
            lane_done_i = 4'hF;
            step();
            check_val("midrst_no_resp", v_o, 1'b0);
        end
        lane_done_i = '0;
        step();

        // Lane 2 never finishes.
        rand_fields();
        lat[0] = 1; lat[1] = 2; lat[2] = 0; lat[3] = 3;
        accept_fields(1'b0);
`ifdef VEC_ISSUE_TIMEOUT_EN
        for (int k = 1; k <= TO; k++) begin
            step();
            check_val("wd_no_v_yet", v_o, 1'b0);
            lane_done_i = done_mask(k);
        end
        step();
        lane_done_i = '0;
        check_val("wd_v", v_o, 1'b1);
        check_val("wd_err", err_o, 1'b1);
        yumi_i = 1'b1;
        step();
        yumi_i = 1'b0;
        check_val("wd_err_clear", err_o, 1'b0);
        check_val("wd_ready", ready_o, 1'b1);
`else
        for (int k = 1; k <= 3 * TO; k++) begin
            step();
            check_val("nowd_no_v", v_o, 1'b0);
            lane_done_i = done_mask(k);
        end
        lane_done_i = '0;
        check_val("nowd_err", err_o, 1'b0);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check_val("nowd_recover", ready_o, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/vec_issue_ctrl.md
# vec_issue_ctrl

Single-instruction issue controller for the vector lane array. Accepts one vector instruction at a time over a valid/ready handshake and registers it. It then pulses `start` to all `lanes_p` lanes and holds opcode, register selects, scalar and write data stable while the lanes execute. It collects every lane's `done` pulse and returns a completion response to the host. It sits between the host/decoder and the lane array plus its vector register file.

## Interface
Parameters:
- `els_p`, 8, number of vector registers
- `lanes_p`, 4, number of lanes driven
- `vdw_p`, 8, bits per element
- `op_width_p`, 4, opcode width
- `timeout_p`, 64, watchdog limit in cycles (used only with the macro)
- `v_addr_width_lp`, derived, `BSG_SAFE_CLOG2(els_p)`

Ports:
- `clk_i`  in  1  clock; single clock domain
- `reset_i`  in  1  synchronous, active-high reset
- `v_i`  in  1  instruction valid
- `ready_o`  out  1  controller can accept an instruction
- `op_i`  in  op_width_p  opcode
- `vd_i`, `vs0_i`, `vs1_i`, `vs2_i`  in  v_addr_width_lp each  destination and source register indices
- `scalar_i`  in  vdw_p  scalar operand
- `w_data_i`  in  lanes_p*vdw_p  external write data, one element per lane
- `lane_op_o`  out  op_width_p  opcode broadcast to lanes
- `lane_start_o`  out  1  one-cycle start pulse to all lanes
- `lane_scalar_o`  out  vdw_p  held scalar
- `lane_w_data_o`  out  lanes_p*vdw_p  held write data
- `vd_o`, `vs0_o`, `vs1_o`, `vs2_o`  out  v_addr_width_lp each  held register selects to the regfile
- `lane_done_i`  in  lanes_p  per-lane done pulses
- `v_o`  out  1  completion response valid
- `yumi_i`  in  1  host consumes the response
- `err_o`  out  1  response carries a timeout error; qualified by `v_o`

## Operation
- FSM states are `s_IDLE`, `s_ISSUE`, `s_WAIT` and `s_RESP`.
- `s_IDLE`:
  - `ready_o`=1.
  - On `v_i & ready_o`, all instruction fields are registered and the FSM moves to `s_ISSUE`.
- `s_ISSUE`:
  - `lane_start_o`=1 for exactly one cycle.
  - The sticky done vector is cleared.
  - Next state is `s_WAIT`.
- `s_WAIT`:
  - `done_r |= lane_done_i` every cycle.
  - When `&(done_r | lane_done_i)`, the FSM moves to `s_RESP`. Lanes may finish in different cycles, and a same-cycle final pulse counts.
- `s_RESP`:
  - `v_o`=1 until `yumi_i`, then the FSM returns to `s_IDLE`.
  - `yumi_i` without `v_o` is ignored.
- Held outputs (`lane_op_o`, selects, scalar, write data) keep their value from acceptance until the next acceptance. Lanes read the opcode combinationally in writeback, so it must not change before done.
- `lane_done_i` is ignored outside `s_WAIT`.
- `v_i` is ignored outside `s_IDLE`, so there is no queuing.
- `op_i` passes through unmodified. The controller decodes nothing except for the watchdog note below.

## Timing
- Reset values: state=`s_IDLE`; `ready_o`=1; `lane_start_o`=0; `v_o`=0; `err_o`=0; every held register and `done_r` = 0.
- Reset mid-operation: the FSM goes to `s_IDLE` and no response is produced. Lanes share `reset_i`.
- Accept in cycle t. Then `lane_start_o` is high in t+1 and the FSM is in `s_WAIT` from t+2.
- Earliest response is one cycle after the last done pulse. Minimum `v_o` latency from acceptance is therefore 2 + lane latency.
- Back-to-back: with `yumi_i` high in the first `s_RESP` cycle, `ready_o` rises the next cycle. Throughput is one instruction per (lane latency + 3) cycles minimum.

## Configuration
- Macro `VEC_ISSUE_TIMEOUT_EN`.
- With the macro defined:
  - A watchdog counts cycles in `s_WAIT` and clears on entry.
  - If it reaches `timeout_p-1` without all done bits set, the FSM enters `s_RESP` with `err_o`=1.
  - `err_o` clears on leaving `s_RESP`.
- Without the macro: no counter, `err_o` tied 0, and `s_WAIT` waits indefinitely.

## Structure
- Shared package `vec_pkg` holds:
  - `state_e` for the four states
  - opcode constants: `OP_READ`=4'b1000; `op[3]` = external-data write; `op[2]` = scalar operand; `op[1:0]`=2'b11 = FMA
  - the `v_addr_width` helper
- Watchdog: `bsg_counter_clear_up`, instantiated only under the macro.
- No other sub-module; FSM and holding registers are flat.

## Test plan
- Reset, then idle: `ready_o`=1, `v_o`=0, `lane_start_o`=0, all held outputs 0.
- Issue `op`=4'b0000, `vd`=3, `vs0`=1, `vs1`=2; all 4 done bits pulse together 6 cycles after start -> single start pulse in t+1, `v_o` rises the cycle after done, `vd_o`=3 held throughout, `err_o`=0.
- Staggered done (lane 0 at +2, lanes 1–3 at +5) -> `v_o` only after lane 3. Stray done pulses in `s_IDLE` -> no response.
- `v_i` held high during `s_WAIT` with a different `op_i` -> `lane_op_o` unchanged, `ready_o`=0. `yumi_i` delayed 3 cycles -> `v_o` held 3 cycles, then next instruction accepted.
- `reset_i` asserted in `s_WAIT` -> next cycle `s_IDLE`, `ready_o`=1, no `v_o`.
- With `VEC_ISSUE_TIMEOUT_EN`, `timeout_p`=8, lane 2 never done -> `v_o`=1 and `err_o`=1 after 8 `s_WAIT` cycles. Without the macro -> `v_o` stays 0.
